traffic_fsm: RTL and testbench

Timed traffic-light controller that produces the 3-bit light selection consumed by the LED colour stage. It cycles through the red, green and yellow phases with per-phase durations set in milliseconds, and serves a latched pedestrian request with a red+walk phase. It also provides a maintenance flashing mode. It sits between the debounced board inputs (button, enable switch) and the LED colour stage.

---
 rtl/traffic_fsm_pkg.sv | 53 +++++
 rtl/ms_tick_gen.sv | 39 +++
 rtl/traffic_fsm.sv | 133 +++++++++++++
 tb/tb_traffic_fsm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_fsm_pkg.sv
// traffic_fsm_pkg
//   Shared definitions for the traffic-light controller and the LED colour stage:
//   - outSel light-selection codes (SEL_*)
//   - FSM state encoding (stateT)
//   - small constant helpers used when sizing counters and decoding outputs
package traffic_fsm_pkg;

  // Light-selection codes consumed by the LED colour stage.
  localparam logic [2:0] SEL_RED    = 3'b000;
  localparam logic [2:0] SEL_GREEN  = 3'b001;
  localparam logic [2:0] SEL_YELLOW = 3'b010;
  localparam logic [2:0] SEL_WALK   = 3'b011;
  localparam logic [2:0] SEL_OFF    = 3'b100;

  typedef enum logic [2:0] {
    StRed      = 3'd0,
    StGreen    = 3'd1,
    StYellow   = 3'd2,
    StWalk     = 3'd3,
    StFlashOn  = 3'd4,
    StFlashOff = 3'd5
  } stateT;

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Light selection shown while the FSM sits in a given state.
  function automatic logic [2:0] selOf(input stateT s);
    logic [2:0] sel;
    sel = SEL_RED;
    unique case (s)
      StRed:      sel = SEL_RED;
      StGreen:    sel = SEL_GREEN;
      StYellow:   sel = SEL_YELLOW;
      StWalk:     sel = SEL_WALK;
      StFlashOn:  sel = SEL_YELLOW;
      StFlashOff: sel = SEL_OFF;
      default:    sel = SEL_RED;
    endcase
    return sel;
  endfunction

  // States in which a pedestrian request may be latched.
  function automatic logic isNormalTraffic(input stateT s);
    return (s == StRed) || (s == StGreen) || (s == StYellow);
  endfunction

  function automatic logic isFlash(input stateT s);
    return (s == StFlashOn) || (s == StFlashOff);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
//   Millisecond tick prescaler. Counts 0 .. C_CLK_FRQ/1000-1 and pulses outTick
//   for one cycle at the terminal count. inClear restarts the count so that the
//   first tick after a clear arrives exactly one millisecond later.
// Ports:
//   clk      in   master clock
//   rstb     in   synchronous reset, active low
//   inClear  in   restart the millisecond count (count is 0 on the next cycle)
//   outTick  out  one-cycle pulse on the last cycle of each millisecond
module ms_tick_gen #(
  parameter int unsigned C_CLK_FRQ = 100000000
) (
  input  logic clk,
  input  logic rstb,
  input  logic inClear,
  output logic outTick
);

  localparam int unsigned Div = C_CLK_FRQ / 1000;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(Div - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (inClear || (cnt == TermCnt)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  // Tick is taken from the count register, so it is glitch-free and
  // independent of inClear in the same cycle.
  assign outTick = (cnt == TermCnt);

endmodule

// File: rtl/traffic_fsm.sv
// traffic_fsm
//   Timed traffic-light controller. Cycles RED -> GREEN -> YELLOW -> (WALK ->
//   GREEN | RED) with per-phase durations in milliseconds, latches pedestrian
//   requests, and offers a maintenance flashing mode (yellow / off).
// Ports:
//   clk             in   master clock
//   rstb            in   synchronous reset, active low
//   inWalkReq       in   debounced pedestrian request; any high cycle registers
//   inEnable        in   1 = normal operation, 0 = maintenance flashing
//   outSel          out  light selection (SEL_* codes), registered
//   outWalkPending  out  a request is latched and not yet served, registered
module traffic_fsm
  import traffic_fsm_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ   = 100000000,
  parameter int unsigned C_RED_MS    = 4000,
  parameter int unsigned C_GREEN_MS  = 5000,
  parameter int unsigned C_YELLOW_MS = 1000,
  parameter int unsigned C_WALK_MS   = 4000,
  parameter int unsigned C_BLINK_MS  = 500
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       inWalkReq,
  input  logic       inEnable,
  output logic [2:0] outSel,
  output logic       outWalkPending
);

  localparam int unsigned MaxMs =
    maxU(maxU(maxU(C_RED_MS, C_GREEN_MS), maxU(C_YELLOW_MS, C_WALK_MS)), C_BLINK_MS);
  localparam int unsigned MsW = $clog2(MaxMs + 1);

  // Last ms-count value of each phase; the phase ends on the tick seen at it.
  localparam logic [MsW-1:0] RedLast    = MsW'(C_RED_MS - 1);
  localparam logic [MsW-1:0] GreenLast  = MsW'(C_GREEN_MS - 1);
  localparam logic [MsW-1:0] YellowLast = MsW'(C_YELLOW_MS - 1);
  localparam logic [MsW-1:0] WalkLast   = MsW'(C_WALK_MS - 1);
  localparam logic [MsW-1:0] BlinkLast  = MsW'(C_BLINK_MS - 1);

  stateT          state;
  stateT          nextState;
  logic [MsW-1:0] msCnt;
  logic [MsW-1:0] durLast;
  logic           tick;
  logic           expire;
  logic           phaseEnd;

  ms_tick_gen #(
    .C_CLK_FRQ (C_CLK_FRQ)
  ) uTickGen (
    .clk     (clk),
    .rstb    (rstb),
    .inClear (phaseEnd),
    .outTick (tick)
  );

  always_comb begin
    durLast = RedLast;
    unique case (state)
      StRed:      durLast = RedLast;
      StGreen:    durLast = GreenLast;
      StYellow:   durLast = YellowLast;
      StWalk:     durLast = WalkLast;
      StFlashOn:  durLast = BlinkLast;
      StFlashOff: durLast = BlinkLast;
      default:    durLast = RedLast;
    endcase
  end

  assign expire = tick && (msCnt == durLast);

  // Priority: inEnable (maintenance entry/exit) over duration expiry.
  always_comb begin
    nextState = state;
    unique case (state)
      StRed: begin
        if (!inEnable)   nextState = StFlashOn;
        else if (expire) nextState = StGreen;
      end
      StGreen: begin
        if (!inEnable)   nextState = StFlashOn;
        else if (expire) nextState = StYellow;
      end
      StYellow: begin
        if (!inEnable)   nextState = StFlashOn;
        else if (expire) nextState = outWalkPending ? StWalk : StRed;
      end
      StWalk: begin
        if (!inEnable)   nextState = StFlashOn;
        else if (expire) nextState = StGreen;
      end
      StFlashOn: begin
        if (inEnable)    nextState = StRed;
        else if (expire) nextState = StFlashOff;
      end
      StFlashOff: begin
        if (inEnable)    nextState = StRed;
        else if (expire) nextState = StFlashOn;
      end
      default: nextState = StRed;
    endcase
  end

  // Every transition goes to a different state, so any change is a phase entry.
  assign phaseEnd = (nextState != state);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state          <= StRed;
      outSel         <= SEL_RED;
      outWalkPending <= 1'b0;
      msCnt          <= '0;
    end else begin
      state  <= nextState;
      outSel <= selOf(nextState);

      if (phaseEnd) begin
        msCnt <= '0;
      end else if (tick) begin
        msCnt <= msCnt + MsW'(1);
      end

      // Clearing on WALK entry or flash entry beats a same-cycle request.
      if ((nextState == StWalk) || isFlash(nextState)) begin
        outWalkPending <= 1'b0;
      end else if (inWalkReq && isNormalTraffic(state)) begin
        outWalkPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_fsm.sv
// tb_traffic_fsm
//   Bench for traffic_fsm at 10 cycles/ms, RED=3, GREEN=4, YELLOW=2, WALK=3,
//   BLINK=2 ms. A phase/remaining-cycles reference model predicts outSel and
//   outWalkPending after every clock edge.
module tb_traffic_fsm;

  localparam int CYC      = 10;
  localparam int RED_MS   = 3;
  localparam int GREEN_MS = 4;
  localparam int YEL_MS   = 2;
  localparam int WALK_MS  = 3;
  localparam int BLINK_MS = 2;

  // Model phases.
  localparam int P_RED   = 0;
  localparam int P_GREEN = 1;
  localparam int P_YEL   = 2;
  localparam int P_WALK  = 3;
  localparam int P_FON   = 4;
  localparam int P_FOFF  = 5;

  logic       clk = 1'b0;
  logic       rstb;
  logic       inWalkReq;
  logic       inEnable;
  logic [2:0] outSel;
  logic       outWalkPending;

  int vectors     = 0;
  int miscompares = 0;

  int ph   = P_RED;
  int rem  = RED_MS * CYC;
  bit pend = 1'b0;
  bit rndEn;

  traffic_fsm #(
    .C_CLK_FRQ   (10000),
    .C_RED_MS    (RED_MS),
    .C_GREEN_MS  (GREEN_MS),
    .C_YELLOW_MS (YEL_MS),
    .C_WALK_MS   (WALK_MS),
    .C_BLINK_MS  (BLINK_MS)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .inWalkReq      (inWalkReq),
    .inEnable       (inEnable),
    .outSel         (outSel),
    .outWalkPending (outWalkPending)
  );

  always #5 clk = ~clk;

  function automatic int phCycles(input int p);
    case (p)
      P_RED:   return RED_MS * CYC;
      P_GREEN: return GREEN_MS * CYC;
      P_YEL:   return YEL_MS * CYC;
      P_WALK:  return WALK_MS * CYC;
      default: return BLINK_MS * CYC;
    endcase
  endfunction

  function automatic logic [2:0] phSel(input int p);
    case (p)
      P_RED:   return 3'b000;
      P_GREEN: return 3'b001;
      P_YEL:   return 3'b010;
      P_WALK:  return 3'b011;
      P_FON:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic modelStep(input bit req, input bit en, input bit rst);
    int  old;
    bit  walkEntry;
    old       = ph;
    walkEntry = 1'b0;
    if (!rst) begin
      ph = P_RED; rem = phCycles(P_RED); pend = 1'b0;
    end else if (!en && ph < P_FON) begin
      ph = P_FON; rem = phCycles(P_FON); pend = 1'b0;
    end else if (en && ph >= P_FON) begin
      ph = P_RED; rem = phCycles(P_RED); pend = 1'b0;
    end else begin
      rem = rem - 1;
      if (rem == 0) begin
        case (ph)
          P_RED:   ph = P_GREEN;
          P_GREEN: ph = P_YEL;
          P_YEL:   ph = pend ? P_WALK : P_RED;
          P_WALK:  ph = P_GREEN;
          P_FON:   ph = P_FOFF;
          default: ph = P_FON;
        endcase
        rem = phCycles(ph);
        if (ph == P_WALK) begin
          pend      = 1'b0;
          walkEntry = 1'b1;
        end
      end
      if (!walkEntry && req && old <= P_YEL) pend = 1'b1;
    end
  endtask

  task automatic checkSel(input string tag, input logic [2:0] exp);
    vectors++;
    assert (outSel === exp) else begin
      miscompares++;
      $error("FAIL %s: outSel=%b expected %b at %0t", tag, outSel, exp, $time);
    end
  endtask

  task automatic checkPend(input string tag, input logic exp);
    vectors++;
    assert (outWalkPending === exp) else begin
      miscompares++;
      $error("FAIL %s: outWalkPending=%b expected %b at %0t", tag, outWalkPending, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic tick(input bit req, input bit en, input bit rst);
    inWalkReq = req;
    inEnable  = en;
    rstb      = rst;
    @(posedge clk);
    modelStep(req, en, rst);
    #1;
    checkSel("model_sel", phSel(ph));
    checkPend("model_pend", pend);
  endtask

  task automatic waitPhase(input int p, input bit req, input bit en);
    for (int i = 0; i < 300 && ph != p; i++) tick(req, en, 1'b1);
    vectors++;
    assert (ph == p) else begin
      miscompares++;
      $error("FAIL wait_phase: phase=%0d expected %0d", ph, p);
    end
  endtask

  initial begin
    inWalkReq = 1'b0;
    inEnable  = 1'b1;
    rstb      = 1'b0;

    // Reset then free run.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    checkSel("reset_sel", 3'b000);
    checkPend("reset_pend", 1'b0);
    repeat (29) tick(1'b0, 1'b1, 1'b1);
    checkSel("red_30_last", 3'b000);
    tick(1'b0, 1'b1, 1'b1);
    checkSel("green_start", 3'b001);
    repeat (200) tick(1'b0, 1'b1, 1'b1);

    // Single-cycle request during GREEN.
    waitPhase(P_GREEN, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    checkPend("req_latched", 1'b1);
    waitPhase(P_WALK, 1'b0, 1'b1);
    checkSel("walk_sel", 3'b011);
    checkPend("walk_clear", 1'b0);
    repeat (150) tick(1'b0, 1'b1, 1'b1);

    // Request held through WALK entry and the WALK phase.
    waitPhase(P_GREEN, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    waitPhase(P_WALK, 1'b1, 1'b1);
    checkPend("walk_entry_req", 1'b0);
    repeat (29) tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    checkSel("after_walk", 3'b001);
    repeat (150) tick(1'b0, 1'b1, 1'b1);

    // Maintenance entry mid-GREEN, exit to a full RED.
    waitPhase(P_GREEN, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    repeat (15) tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    checkSel("flash_on", 3'b010);
    checkPend("flash_pend", 1'b0);
    for (int i = 0; i < 70; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    checkSel("leave_red", 3'b000);
    repeat (29) tick(1'b0, 1'b1, 1'b1);
    checkSel("leave_red_full", 3'b000);
    tick(1'b0, 1'b1, 1'b1);
    checkSel("leave_red_end", 3'b001);

    // Reset mid-YELLOW with a request pending.
    waitPhase(P_GREEN, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    waitPhase(P_YEL, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b1, 1'b1);
    checkPend("pre_reset_pend", 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    checkSel("mid_reset_sel", 3'b000);
    checkPend("mid_reset_pend", 1'b0);
    repeat (29) tick(1'b0, 1'b1, 1'b1);
    checkSel("post_reset_red", 3'b000);
    tick(1'b0, 1'b1, 1'b1);
    checkSel("post_reset_green", 3'b001);

    // Randomized traffic.
    rndEn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rndEn = ~rndEn;
      tick(($urandom_range(0, 14) == 0), rndEn, ($urandom_range(0, 499) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
